// File: rtl/data_bus_bridge_if.sv
// Core-side load/store port and word-aligned memory port of the data bus bridge.
// master = the bridge itself, slave = the core/memory environment around it.
interface data_bus_bridge_if;
  logic [31:0] core_address;
  logic [1:0]  core_width;
  logic [31:0] core_wdata;
  logic        core_read;
  logic        core_write;
  logic [31:0] core_rdata;
  logic        core_stall;

  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_we;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    input  core_address, core_width, core_wdata, core_read, core_write,
    input  mem_ready, mem_rdata,
    output core_rdata, core_stall,
    output mem_address, mem_wdata, mem_be, mem_we, mem_valid
  );

  modport slave (
    output core_address, core_width, core_wdata, core_read, core_write,
    output mem_ready, mem_rdata,
    input  core_rdata, core_stall,
    input  mem_address, mem_wdata, mem_be, mem_we, mem_valid
  );
endinterface

// File: rtl/data_bus_bridge.sv
// Splits byte/half/word core accesses into one or two aligned word transactions.
// Min 2 cycles (stall high), +1 when split, +1 per mem wait; core held by core_stall.
module data_bus_bridge (
  input  logic              clock,
  input  logic              reset_n,
  data_bus_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND, DONE} state_t;

  state_t state, state_nxt;
  logic   req;
  logic   accept;
  logic   stall;

  logic [1:0]  off;
  logic [3:0]  size_mask;
  logic [7:0]  lanes;
  logic [63:0] wdata_wide;

  logic [31:0] hi_addr_q;
  logic [3:0]  be_hi_q;
  logic [31:0] wdata_hi_q;
  logic        split_q;
  logic [1:0]  off_q;
  logic [3:0]  size_mask_q;
  logic        is_read_q;
  logic [31:0] word0_q;

  assign req    = bus.core_read | bus.core_write;
  assign accept = bus.mem_valid & bus.mem_ready;
  assign off    = bus.core_address[1:0];

  always_comb begin
    case (bus.core_width)
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  // Lanes [3:0] belong to the first word, lanes [7:4] spill into the next word.
  assign lanes      = {4'b0000, size_mask} << off;
  assign wdata_wide = {32'b0, bus.core_wdata} << {off, 3'b000};

  function automatic logic [31:0] align_rdata(input logic [31:0] hi, input logic [31:0] lo,
                                              input logic [1:0] o, input logic [3:0] m);
    logic [63:0] pair;
    logic [31:0] mask;
    pair = {hi, lo} >> {o, 3'b000};
    mask = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return pair[31:0] & mask;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        stall = req;
        if (req) state_nxt = FIRST;
      end
      FIRST: begin
        stall = 1'b1;
        if (accept) state_nxt = split_q ? SECOND : DONE;
      end
      SECOND: begin
        stall = 1'b1;
        if (accept) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.core_stall = stall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.mem_valid   <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_be      <= 4'b0;
      bus.mem_address <= 32'b0;
      bus.mem_wdata   <= 32'b0;
      bus.core_rdata  <= 32'b0;
      hi_addr_q       <= 32'b0;
      be_hi_q         <= 4'b0;
      wdata_hi_q      <= 32'b0;
      split_q         <= 1'b0;
      off_q           <= 2'b0;
      size_mask_q     <= 4'b0;
      is_read_q       <= 1'b0;
      word0_q         <= 32'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            bus.mem_valid   <= 1'b1;
            bus.mem_we      <= ~bus.core_read;
            bus.mem_address <= {bus.core_address[31:2], 2'b00};
            bus.mem_be      <= lanes[3:0];
            bus.mem_wdata   <= wdata_wide[31:0];
            hi_addr_q       <= {bus.core_address[31:2], 2'b00} + 32'd4;
            be_hi_q         <= lanes[7:4];
            wdata_hi_q      <= wdata_wide[63:32];
            split_q         <= |lanes[7:4];
            off_q           <= off;
            size_mask_q     <= size_mask;
            is_read_q       <= bus.core_read;
          end
        end
        FIRST: begin
          if (accept) begin
            word0_q <= bus.mem_rdata;
            if (split_q) begin
              bus.mem_address <= hi_addr_q;
              bus.mem_be      <= be_hi_q;
              bus.mem_wdata   <= wdata_hi_q;
            end else begin
              bus.mem_valid <= 1'b0;
              if (is_read_q)
                bus.core_rdata <= align_rdata(32'b0, bus.mem_rdata, off_q, size_mask_q);
            end
          end
        end
        SECOND: begin
          // The second word is consumed straight off the bus; only word0 needs holding.
          if (accept) begin
            bus.mem_valid <= 1'b0;
            if (is_read_q)
              bus.core_rdata <= align_rdata(bus.mem_rdata, word0_q, off_q, size_mask_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_bridge.sv
// Randomized bench for data_bus_bridge: byte-addressed reference memory predicts
// load data, per-word transactions and stall length; a responder models the memory.
module tb_data_bus_bridge;
  logic clock = 1'b0;
  logic reset_n;

  data_bus_bridge_if bus();

  data_bus_bridge dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference memory (byte-level, what a correct bridge should have produced).
  logic [7:0]  ref_mem [logic [31:0]];
  // Memory as actually written by the DUT (word-level, served by the responder).
  logic [31:0] wmem    [logic [31:0]];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  function automatic logic [31:0] wmem_rd(input logic [31:0] wa);
    logic [31:0] w;
    if (wmem.exists(wa)) return wmem[wa];
    for (int i = 0; i < 4; i++) w[8*i +: 8] = init_byte(wa + 32'(i));
    return w;
  endfunction

  task automatic preload(input logic [31:0] wa, input logic [31:0] val);
    wmem[wa] = val;
    for (int i = 0; i < 4; i++) ref_mem[wa + 32'(i)] = val[8*i +: 8];
  endtask

  logic [31:0] t_addr  [$];
  logic [3:0]  t_be    [$];
  logic        t_we    [$];
  logic [31:0] t_wdata [$];
  int          forced_wait = -1;
  int          waits_used  = 0;
  logic [31:0] last_rd     = 32'b0;

  initial begin : responder
    int          left;
    bit          pending;
    logic [31:0] s_addr, s_wdata, w;
    logic [3:0]  s_be;
    logic        s_we;
    left = 0;
    pending = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'b0;
    forever begin
      @(negedge clock);
      if (!bus.mem_valid) begin
        pending = 0;
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
      end else begin
        if (!pending) begin
          left = (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, 2));
          waits_used += left;
          pending = 1;
          s_addr = bus.mem_address; s_be = bus.mem_be;
          s_we = bus.mem_we; s_wdata = bus.mem_wdata;
        end else begin
          check("hold_addr", bus.mem_address, s_addr);
          check("hold_be", 32'(bus.mem_be), 32'(s_be));
          check("hold_we", 32'(bus.mem_we), 32'(s_we));
          check("hold_wdata", bus.mem_wdata, s_wdata);
        end
        if (left == 0) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = wmem_rd(bus.mem_address);
          if (bus.mem_we) begin
            w = wmem_rd(bus.mem_address);
            for (int i = 0; i < 4; i++)
              if (bus.mem_be[i]) w[8*i +: 8] = bus.mem_wdata[8*i +: 8];
            wmem[bus.mem_address] = w;
          end
          t_addr.push_back(bus.mem_address);
          t_be.push_back(bus.mem_be);
          t_we.push_back(bus.mem_we);
          t_wdata.push_back(bus.mem_wdata);
          pending = 0;
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = $urandom;
          left--;
        end
      end
    end
  end

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // One core access; fw >= 0 forces that many wait cycles on every mem phase.
  task automatic do_access(input bit rd, input logic [31:0] addr, input logic [1:0] width,
                           input logic [31:0] wdata, input int fw, input string tag,
                           output logic [31:0] got);
    int          n, nw, cyc;
    logic [31:0] a;
    logic [31:0] ea [2];
    logic [3:0]  ebe [2];
    logic [31:0] edat [2];
    logic [31:0] exp_rd;
    n  = (width == 2'd0) ? 1 : (width == 2'd1) ? 2 : 4;
    nw = 0;
    exp_rd = 32'b0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      if (nw == 0 || ea[nw-1] != {a[31:2], 2'b00}) begin
        ea[nw] = {a[31:2], 2'b00}; ebe[nw] = 4'b0; edat[nw] = 32'b0; nw++;
      end
      ebe[nw-1][a[1:0]] = 1'b1;
      edat[nw-1][{a[1:0], 3'b000} +: 8] = wdata[8*i +: 8];
      if (rd) exp_rd[8*i +: 8] = ref_rd(a);
      else    ref_mem[a] = wdata[8*i +: 8];
    end
    t_addr.delete(); t_be.delete(); t_we.delete(); t_wdata.delete();
    waits_used = 0;
    forced_wait = fw;
    @(negedge clock);
    bus.core_address = addr;
    bus.core_width   = width;
    bus.core_wdata   = wdata;
    bus.core_read    = rd;
    bus.core_write   = rd ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    cyc = 0;
    while (bus.core_stall && cyc < 60) begin
      cyc++;
      @(negedge clock);
      #1;
    end
    check({tag, "_stall_cycles"}, 32'(cyc), 32'(1 + nw + waits_used));
    check({tag, "_valid_done"}, 32'(bus.mem_valid), 32'd0);
    if (rd) last_rd = exp_rd;
    got = bus.core_rdata;
    check({tag, "_rdata"}, bus.core_rdata, last_rd);
    bus.core_read  = 1'b0;
    bus.core_write = 1'b0;
    forced_wait = -1;
    check({tag, "_ntxn"}, 32'(t_addr.size()), 32'(nw));
    for (int k = 0; k < nw && k < t_addr.size(); k++) begin
      check({tag, "_addr"}, t_addr[k], ea[k]);
      check({tag, "_be"}, 32'(t_be[k]), 32'(ebe[k]));
      check({tag, "_we"}, 32'(t_we[k]), 32'(!rd));
      if (!rd) check({tag, "_wdata"}, t_wdata[k] & be_mask(ebe[k]), edat[k]);
    end
  endtask

  initial begin : main
    logic [31:0] r;
    logic [31:0] a;
    reset_n = 1'b0;
    bus.core_address = 32'b0;
    bus.core_width   = 2'b0;
    bus.core_wdata   = 32'b0;
    bus.core_read    = 1'b0;
    bus.core_write   = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_stall", 32'(bus.core_stall), 32'd0);
    check("rst_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_be", 32'(bus.mem_be), 32'd0);
    check("rst_addr", bus.mem_address, 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_rdata", bus.core_rdata, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    preload(32'h100, 32'hDEADBEEF);
    do_access(1'b1, 32'h100, 2'd2, $urandom, 0, "lw100", r);
    check("lw100_val", r, 32'hDEADBEEF);

    preload(32'h100, 32'h80FFFFFF);
    do_access(1'b1, 32'h103, 2'd0, $urandom, 0, "lb103", r);
    check("lb103_val", r, 32'h00000080);

    do_access(1'b0, 32'h102, 2'd2, 32'h11223344, 0, "sw102", r);
    check("sw102_wdata0", t_wdata[0], 32'h33440000);
    check("sw102_wdata1", t_wdata[1], 32'h00001122);
    check("sw102_be0", 32'(t_be[0]), 32'hC);

    preload(32'h200, 32'hAABBCCDD);
    preload(32'h204, 32'h11223344);
    do_access(1'b1, 32'h203, 2'd1, $urandom, 0, "lh203", r);
    check("lh203_val", r, 32'h000044AA);

    do_access(1'b1, 32'hFFFFFFFE, 2'd2, $urandom, 3, "lw_wrap", r);
    check("lw_wrap_addr0", t_addr[0], 32'hFFFFFFFC);
    check("lw_wrap_addr1", t_addr[1], 32'h00000000);

    // Reset while the first phase is waiting on memory.
    t_addr.delete(); t_be.delete(); t_we.delete(); t_wdata.delete();
    forced_wait = 5;
    @(negedge clock);
    bus.core_address = 32'h300;
    bus.core_width   = 2'd2;
    bus.core_read    = 1'b1;
    @(negedge clock);
    #1;
    check("midrst_pre_valid", 32'(bus.mem_valid), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.mem_valid), 32'd0);
    check("midrst_be", 32'(bus.mem_be), 32'd0);
    check("midrst_addr", bus.mem_address, 32'd0);
    check("midrst_rdata", bus.core_rdata, 32'd0);
    check("midrst_stall_req", 32'(bus.core_stall), 32'd1);
    bus.core_read = 1'b0;
    #1;
    check("midrst_stall_noreq", 32'(bus.core_stall), 32'd0);
    last_rd = 32'b0;
    @(negedge clock);
    reset_n = 1'b1;
    forced_wait = -1;
    repeat (4) begin
      @(negedge clock);
      #1;
      check("postrst_stall", 32'(bus.core_stall), 32'd0);
      check("postrst_valid", 32'(bus.mem_valid), 32'd0);
    end
    check("postrst_ntxn", 32'(t_addr.size()), 32'd0);

    for (int t = 0; t < 150; t++) begin
      a = {22'b0, 10'($urandom)};
      if (t % 5 == 0) a = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
      do_access(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), $urandom, -1, "rnd", r);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
